// File: rtl/knn_topk_merge.sv
// knn_topk_merge
//   Streaming top-K merge of two ascending candidate lists. Each batch takes
//   K distance words from each input stream and emits the K globally smallest
//   words, ascending, on the output stream. Extra input words are consumed
//   and discarded so that both producers always finish their batch.
//
// Ports
//   ap_clk / ap_rst_n        : clock, asynchronous active-low reset
//   ap_start                 : batch enable, sampled in IDLE
//   ap_done / ap_ready       : one-cycle pulse when a batch completes
//   ap_idle                  : high while waiting for ap_start
//   Input_1_V_V (+vld/ack)   : list A words
//   Input_2_V_V (+vld/ack)   : list B words
//   Output_1_V_V (+vld/ack)  : merged output words
//   A word transfers on a rising edge where its vld and ack are both high.
module knn_topk_merge #(
  parameter int K         = 10,
  parameter int DATA_BITS = 32,
  parameter int CNT_BITS  = 7
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 ap_start,
  output logic                 ap_done,
  output logic                 ap_idle,
  output logic                 ap_ready,
  input  logic [DATA_BITS-1:0] Input_1_V_V,
  input  logic                 Input_1_V_V_ap_vld,
  output logic                 Input_1_V_V_ap_ack,
  input  logic [DATA_BITS-1:0] Input_2_V_V,
  input  logic                 Input_2_V_V_ap_vld,
  output logic                 Input_2_V_V_ap_ack,
  output logic [DATA_BITS-1:0] Output_1_V_V,
  output logic                 Output_1_V_V_ap_vld,
  input  logic                 Output_1_V_V_ap_ack
);

  localparam logic [CNT_BITS-1:0] K_C    = CNT_BITS'(K);
  localparam logic [CNT_BITS-1:0] K_LAST = CNT_BITS'(K - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state;
  logic [DATA_BITS-1:0] h1, h2;
  logic                 hv1, hv2;
  logic [CNT_BITS-1:0]  c1, c2, oc;
  logic [DATA_BITS-1:0] out_data;
  logic                 out_vld;

  logic                 active;
  logic                 take1, take2;
  logic                 slot_free;
  logic                 ex1, ex2;
  logic                 pick1, pick2;
  logic                 load;
  logic                 last_load;
  logic [DATA_BITS-1:0] load_data;
  logic                 drain_done;

  assign Output_1_V_V        = out_data;
  assign Output_1_V_V_ap_vld = out_vld;

  // Input acks come only from registered state so they never depend on the
  // producer's same-cycle vld. A stream is acked only while its head is empty.
  assign active             = (state == RUN) || (state == DRAIN);
  assign Input_1_V_V_ap_ack = active && !hv1 && (c1 < K_C);
  assign Input_2_V_V_ap_ack = active && !hv2 && (c2 < K_C);

  assign take1 = Input_1_V_V_ap_vld && Input_1_V_V_ap_ack;
  assign take2 = Input_2_V_V_ap_vld && Input_2_V_V_ap_ack;

  // The output register can take a new word if it is empty or being drained
  // on this very edge.
  assign slot_free = !out_vld || Output_1_V_V_ap_ack;

  // A stream is exhausted once all K words were consumed and none is held.
  assign ex1 = (c1 == K_C) && !hv1;
  assign ex2 = (c2 == K_C) && !hv2;

  // Merge decision: smaller head wins, ties go to list A. A lone head may only
  // be emitted once the other stream can no longer deliver a smaller word.
  always_comb begin
    pick1 = 1'b0;
    pick2 = 1'b0;
    if ((state == RUN) && slot_free && (oc < K_C)) begin
      if (hv1 && hv2) begin
        if (h1 <= h2) pick1 = 1'b1;
        else          pick2 = 1'b1;
      end else if (hv1 && ex2) begin
        pick1 = 1'b1;
      end else if (hv2 && ex1) begin
        pick2 = 1'b1;
      end
    end
  end

  assign load       = pick1 || pick2;
  assign load_data  = pick1 ? h1 : h2;
  assign last_load  = load && (oc == K_LAST);
  assign drain_done = (c1 == K_C) && (c2 == K_C) && slot_free;

  // Control FSM together with heads, counters and the output register.
  // Entering DRAIN drops both heads; any later input word only bumps its
  // counter so the producers can complete the batch.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state    <= IDLE;
      h1       <= '0;
      h2       <= '0;
      hv1      <= 1'b0;
      hv2      <= 1'b0;
      c1       <= '0;
      c2       <= '0;
      oc       <= '0;
      out_data <= '0;
      out_vld  <= 1'b0;
      ap_done  <= 1'b0;
      ap_ready <= 1'b0;
      ap_idle  <= 1'b1;
    end else begin
      ap_done  <= 1'b0;
      ap_ready <= 1'b0;

      if (out_vld && Output_1_V_V_ap_ack) out_vld <= 1'b0;
      if (load) begin
        out_data <= load_data;
        out_vld  <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (ap_start) begin
            c1      <= '0;
            c2      <= '0;
            oc      <= '0;
            hv1     <= 1'b0;
            hv2     <= 1'b0;
            ap_idle <= 1'b0;
            state   <= RUN;
          end
        end

        RUN: begin
          if (take1) begin
            h1  <= Input_1_V_V;
            hv1 <= 1'b1;
            c1  <= c1 + 1'b1;
          end
          if (take2) begin
            h2  <= Input_2_V_V;
            hv2 <= 1'b1;
            c2  <= c2 + 1'b1;
          end
          if (pick1) hv1 <= 1'b0;
          if (pick2) hv2 <= 1'b0;
          if (load)  oc  <= oc + 1'b1;
          if (last_load) begin
            hv1   <= 1'b0;
            hv2   <= 1'b0;
            state <= DRAIN;
          end
        end

        DRAIN: begin
          if (take1) c1 <= c1 + 1'b1;
          if (take2) c2 <= c2 + 1'b1;
          if (drain_done) begin
            ap_done  <= 1'b1;
            ap_ready <= 1'b1;
            state    <= DONE;
          end
        end

        DONE: begin
          ap_idle <= 1'b1;
          state   <= IDLE;
        end

        default: begin
          ap_idle <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_knn_topk_merge.sv
// tb_knn_topk_merge
//   Directed bench for knn_topk_merge with K=4. Two driver tasks feed list A
//   and list B through the vld/ack handshake, a collector acks and records
//   output words, and a monitor counts ap_done pulses. Expected outputs are
//   hand-computed for directed cases and produced by sorting A and B for the
//   randomised cases.
module tb_knn_topk_merge;

  localparam int K  = 4;
  localparam int DW = 32;

  typedef logic [DW-1:0] list_t [K];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ap_start = 1'b0;
  logic          ap_done, ap_idle, ap_ready;
  logic [DW-1:0] in1 = '0, in2 = '0;
  logic          vld1 = 1'b0, vld2 = 1'b0;
  logic          ack1, ack2;
  logic [DW-1:0] out_data;
  logic          out_vld;
  logic          out_ack = 1'b0;

  int            check_count = 0;
  int            pass_count = 0;
  int            done_count = 0;
  int            ack_mode = 0;
  bit            abort = 1'b0;
  logic [DW-1:0] recv[$];
  logic          pend = 1'b0;
  logic [DW-1:0] pend_data = '0;

  knn_topk_merge #(.K(K), .DATA_BITS(DW), .CNT_BITS(7)) dut (
    .ap_clk              (clk),
    .ap_rst_n            (rst_n),
    .ap_start            (ap_start),
    .ap_done             (ap_done),
    .ap_idle             (ap_idle),
    .ap_ready            (ap_ready),
    .Input_1_V_V         (in1),
    .Input_1_V_V_ap_vld  (vld1),
    .Input_1_V_V_ap_ack  (ack1),
    .Input_2_V_V         (in2),
    .Input_2_V_V_ap_vld  (vld2),
    .Input_2_V_V_ap_ack  (ack2),
    .Output_1_V_V        (out_data),
    .Output_1_V_V_ap_vld (out_vld),
    .Output_1_V_V_ap_ack (out_ack)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Output side: choose ack at each falling edge, record words that will
  // transfer on the next rising edge, and require a stalled word to hold.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend    = 1'b0;
        out_ack = 1'b0;
      end else begin
        if (pend) begin
          checkOutput("out_hold_vld", 32'(out_vld), 32'd1);
          checkOutput("out_hold_data", out_data, pend_data);
        end
        out_ack = (ack_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
        if (out_vld && out_ack) recv.push_back(out_data);
        pend      = out_vld && !out_ack;
        pend_data = out_data;
      end
    end
  end

  // Completion monitor: counts cycles with ap_done/ap_ready high.
  initial begin
    forever begin
      @(negedge clk);
      if (ap_done || ap_ready) begin
        done_count++;
        checkOutput("ready_with_done", 32'(ap_ready), 32'(ap_done));
      end
    end
  end

  task automatic sendWord(input int port, input logic [DW-1:0] v, input int gap);
    int n = 0;
    logic a;
    repeat (gap) @(negedge clk);
    if (port == 1) begin in1 = v; vld1 = 1'b1; end
    else           begin in2 = v; vld2 = 1'b1; end
    a = (port == 1) ? ack1 : ack2;
    while (!abort && !a && n < 500) begin
      @(negedge clk);
      n++;
      a = (port == 1) ? ack1 : ack2;
    end
    if (n >= 500) checkOutput((port == 1) ? "ack1_timeout" : "ack2_timeout", 32'(n), 32'd0);
    if (!abort && a) begin
      @(posedge clk);
      @(negedge clk);
    end
    if (port == 1) vld1 = 1'b0;
    else           vld2 = 1'b0;
  endtask

  task automatic sendList(input int port, input list_t vals, input bit gaps);
    for (int i = 0; i < K; i++) begin
      if (abort) break;
      sendWord(port, vals[i], gaps ? int'($urandom_range(0, 3)) : 0);
    end
  endtask

  // One full batch: drive both lists, wait for K outputs and the done pulse,
  // then compare words and pulse count.
  task automatic applyStimulus(input string name, input list_t a, input list_t b,
                               input list_t exp, input bit gaps);
    int base;
    int n;
    recv.delete();
    base = done_count;
    fork
      sendList(1, a, gaps);
      sendList(2, b, gaps);
    join
    n = 0;
    while ((recv.size() < K || done_count == base) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) checkOutput({name, "_timeout"}, 32'(n), 32'd0);
    repeat (4) @(negedge clk);
    checkOutput({name, "_count"}, 32'(recv.size()), 32'(K));
    for (int i = 0; i < K; i++)
      checkOutput($sformatf("%s_out%0d", name, i),
                  (i < recv.size()) ? recv[i] : 32'hDEADBEEF, exp[i]);
    checkOutput({name, "_done_pulses"}, 32'(done_count - base), 32'd1);
  endtask

  initial begin
    list_t         a, b, e;
    logic [DW-1:0] pool[$];
    logic [DW-1:0] acc;
    int            n;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_out_vld", 32'(out_vld), 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_ack1", 32'(ack1), 32'd0);
    checkOutput("rst_ack2", 32'(ack2), 32'd0);
    checkOutput("rst_idle", 32'(ap_idle), 32'd1);
    checkOutput("rst_done", 32'(ap_done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_no_start_ack1", 32'(ack1), 32'd0);
    ap_start = 1'b1;
    @(negedge clk);

    // Basic merge
    a = '{1, 5, 9, 13};  b = '{2, 3, 20, 30};  e = '{1, 2, 3, 5};
    applyStimulus("basic", a, b, e, 1'b0);

    // Ties resolve to list A first; value sequence 7,7,7,8
    a = '{7, 7, 8, 9};   b = '{7, 8, 8, 8};    e = '{7, 7, 7, 8};
    applyStimulus("ties", a, b, e, 1'b0);

    // List A exhausted first, B fully drained; ap_start low so DUT parks
    ap_start = 1'b0;
    a = '{1, 2, 3, 4};   b = '{10, 11, 12, 13}; e = '{1, 2, 3, 4};
    applyStimulus("exhaust", a, b, e, 1'b0);
    checkOutput("exhaust_idle", 32'(ap_idle), 32'd1);
    checkOutput("exhaust_ack2_off", 32'(ack2), 32'd0);
    ap_start = 1'b1;

    // Back-to-back batches
    a = '{50, 60, 70, 80}; b = '{55, 65, 75, 85}; e = '{50, 55, 60, 65};
    applyStimulus("b2b_1", a, b, e, 1'b0);
    a = '{0, 1, 2, 3};   b = '{0, 0, 5, 6};     e = '{0, 0, 0, 1};
    applyStimulus("b2b_2", a, b, e, 1'b0);

    // Reset in the middle of a batch after three outputs
    recv.delete();
    a = '{10, 20, 30, 40}; b = '{15, 25, 35, 45};
    fork
      sendList(1, a, 1'b0);
      sendList(2, b, 1'b0);
    join_none
    n = 0;
    while (recv.size() < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) checkOutput("midrst_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_vld", 32'(out_vld), 32'd0);
    checkOutput("midrst_out_data", out_data, 32'd0);
    checkOutput("midrst_ack1", 32'(ack1), 32'd0);
    checkOutput("midrst_ack2", 32'(ack2), 32'd0);
    checkOutput("midrst_idle", 32'(ap_idle), 32'd1);
    abort = 1'b1;
    repeat (3) @(negedge clk);
    vld1  = 1'b0;
    vld2  = 1'b0;
    abort = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("postrst_no_word", 32'(out_vld), 32'd0);
    a = '{100, 101, 102, 103}; b = '{99, 104, 105, 106}; e = '{99, 100, 101, 102};
    applyStimulus("postrst", a, b, e, 1'b0);

    // Randomised sorted lists with input gaps and 30% output ack duty
    ack_mode = 1;
    for (int t = 0; t < 40; t++) begin
      acc = DW'($urandom_range(0, 20));
      for (int i = 0; i < K; i++) begin
        acc  = acc + DW'($urandom_range(0, 6));
        a[i] = acc;
      end
      acc = DW'($urandom_range(0, 20));
      for (int i = 0; i < K; i++) begin
        acc  = acc + DW'($urandom_range(0, 6));
        b[i] = acc;
      end
      pool.delete();
      for (int i = 0; i < K; i++) begin
        pool.push_back(a[i]);
        pool.push_back(b[i]);
      end
      pool.sort();
      for (int i = 0; i < K; i++) e[i] = pool[i];
      applyStimulus($sformatf("rnd%0d", t), a, b, e, 1'b1);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
